// File: rtl/aes_cipher_arb.sv
// Round-robin arbiter/sequencer sharing one external AES-128 core among NREQ
// requesters, with a one-entry tagged response register and a completion watchdog.
module aes_cipher_arb #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*128-1:0]  req_key,
  input  logic [NREQ*128-1:0]  req_text,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [127:0]         rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 core_ld,
  output logic [127:0]         core_key,
  output logic [127:0]         core_text_in,
  input  logic                 core_done,
  input  logic [127:0]         core_text_out
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] last_grant_reg;
  logic [7:0]     cnt_reg;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic           grant_en;
  logic           run_timeout;
  logic [4:0]     cand_sum;
  logic [4:0]     cand_wrap;

  // Cyclic search starting just after the previous winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand_wrap   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_sum  = 5'(last_grant_reg) + 5'(k);
      cand_wrap = (cand_sum >= 5'(NREQ)) ? cand_sum - 5'(NREQ) : cand_sum;
      if (!grant_found && req_valid[cand_wrap[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_wrap[IDW-1:0];
      end
    end
  end

  assign grant_en    = (state_reg == IDLE) && grant_found && (!rsp_valid || rsp_ready);
  assign req_ready   = grant_en ? (NREQ'(1) << grant_idx) : '0;
  assign run_timeout = (cnt_reg == 8'(TIMEOUT - 1));
  assign busy        = (state_reg != IDLE);
  assign core_ld     = (state_reg == LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_en) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (core_done || run_timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Job registers double as the core inputs so they stay stable until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= IDW'(NREQ - 1);
      core_key       <= '0;
      core_text_in   <= '0;
    end else if (grant_en) begin
      last_grant_reg <= grant_idx;
      core_key       <= req_key[{grant_idx, 7'd0} +: 128];
      core_text_in   <= req_text[{grant_idx, 7'd0} +: 128];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt_reg <= '0;
    else if (state_reg == LOAD)  cnt_reg <= '0;
    else if (state_reg == RUN)   cnt_reg <= cnt_reg + 8'd1;
  end

  // core_done outranks the deadline; completions outside RUN are stale and dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (state_reg == RUN && core_done) begin
      rsp_valid <= 1'b1;
      rsp_err   <= 1'b0;
      rsp_id    <= last_grant_reg;
      rsp_data  <= core_text_out;
    end else if (state_reg == RUN && run_timeout) begin
      rsp_valid <= 1'b1;
      rsp_err   <= 1'b1;
      rsp_id    <= last_grant_reg;
      rsp_data  <= '0;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_cipher_arb.sv
// Bench for aes_cipher_arb: two instances (TIMEOUT 32 and 12), each driving a
// 12-cycle stand-in core; table-driven jobs plus hand-written corner sequences.
module tb_aes_cipher_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_TXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NREQ-1:0]     req_valid [2];
  logic [NREQ-1:0]     req_ready [2];
  logic [NREQ*128-1:0] req_key;
  logic [NREQ*128-1:0] req_text;
  logic                rsp_valid [2];
  logic                rsp_ready [2];
  logic [IDW-1:0]      rsp_id [2];
  logic [127:0]        rsp_data [2];
  logic                rsp_err [2];
  logic                busy [2];
  logic                core_ld [2];
  logic [127:0]        core_key [2];
  logic [127:0]        core_text_in [2];
  logic                core_done [2];
  logic [127:0]        core_text_out [2];
  logic                suppress [2];
  logic                force_done [2];
  logic [3:0]          cm_cnt [2]  = '{4'd0, 4'd0};
  logic [127:0]        cm_key [2]  = '{128'd0, 128'd0};
  logic [127:0]        cm_text [2] = '{128'd0, 128'd0};

  aes_cipher_arb #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_key(req_key), .req_text(req_text),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_id(rsp_id[0]),
    .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]), .busy(busy[0]),
    .core_ld(core_ld[0]), .core_key(core_key[0]), .core_text_in(core_text_in[0]),
    .core_done(core_done[0]), .core_text_out(core_text_out[0])
  );

  aes_cipher_arb #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(12)) dut12 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_key(req_key), .req_text(req_text),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_id(rsp_id[1]),
    .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]), .busy(busy[1]),
    .core_ld(core_ld[1]), .core_key(core_key[1]), .core_text_in(core_text_in[1]),
    .core_done(core_done[1]), .core_text_out(core_text_out[1])
  );

  // Stand-in core: FIPS-197 vector answered by constant, anything else key^text.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t);
    if (k == FIPS_KEY && t == FIPS_TXT) return FIPS_CT;
    return k ^ t;
  endfunction

  // Not reset by rst: it models the external core. Done lands 12 cycles after core_ld.
  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (core_ld[n]) begin
        cm_cnt[n]  <= 4'd12;
        cm_key[n]  <= core_key[n];
        cm_text[n] <= core_text_in[n];
      end else if (cm_cnt[n] != 4'd0) begin
        cm_cnt[n] <= cm_cnt[n] - 4'd1;
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      core_done[n]     = (cm_cnt[n] == 4'd1 && !suppress[n]) || force_done[n];
      core_text_out[n] = core_fn(cm_key[n], cm_text[n]);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid[0] = '0; req_valid[1] = '0;
    rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One job end to end on instance sel; checks grant, load, latency and response.
  task automatic run_job(input int sel, input int id, input logic [127:0] key,
                         input logic [127:0] text, input logic [127:0] exp_data,
                         input logic exp_err, input int exp_lat);
    int g;
    logic [NREQ-1:0] want;
    want = NREQ'(1) << id;
    @(posedge clk); #1;
    req_key[id*128 +: 128]  = key;
    req_text[id*128 +: 128] = text;
    req_valid[sel] = want;
    rsp_ready[sel] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready[sel] != '0) break;
    end
    g = cyc;
    check("grant", 128'(req_ready[sel]), 128'(want));
    @(posedge clk); #1 req_valid[sel] = '0;
    @(negedge clk);
    check("core_ld", 128'(core_ld[sel]), 128'd1);
    check("busy", 128'(busy[sel]), 128'd1);
    check("core_key", core_key[sel], key);
    check("core_text_in", core_text_in[sel], text);
    for (int i = 0; i < exp_lat + 10; i++) begin
      @(negedge clk);
      if (rsp_valid[sel]) break;
    end
    check("rsp_latency", 128'(cyc - g), 128'(exp_lat));
    check("rsp_id", 128'(rsp_id[sel]), 128'(id));
    check("rsp_data", rsp_data[sel], exp_data);
    check("rsp_err", 128'(rsp_err[sel]), 128'(exp_err));
    @(negedge clk);
    check("rsp_clear", 128'(rsp_valid[sel]), 128'd0);
  endtask

  typedef struct {
    int           sel;
    int           id;
    logic [127:0] key;
    logic [127:0] text;
    logic [127:0] exp_data;
    logic         exp_err;
    int           exp_lat;
    logic         sup;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    int bad;
    int gcount;
    int gid [5];
    int gcyc [5];
    int rr_exp [5];
    logic [127:0] held;

    rr_exp = '{0, 1, 2, 3, 0};
    vecs[0] = '{0, 2, FIPS_KEY, FIPS_TXT, FIPS_CT, 1'b0, 14, 1'b0};
    vecs[1] = '{0, 0, {4{32'h11111111}}, {4{32'h22222222}}, {4{32'h33333333}}, 1'b0, 14, 1'b0};
    vecs[2] = '{0, 3, {4{32'hffffffff}}, {2{64'h0123456789abcdef}}, {2{64'hfedcba9876543210}}, 1'b0, 14, 1'b0};
    vecs[3] = '{0, 1, 128'hdeadbeef00000000cafef00d12345678, 128'h00000000deadbeef0000000011111111,
                128'hdeadbeefdeadbeefcafef00d03254769, 1'b0, 14, 1'b0};
    vecs[4] = '{0, 3, 128'd0, {4{32'ha5a5a5a5}}, 128'd0, 1'b1, 34, 1'b1};
    vecs[5] = '{1, 1, FIPS_KEY, FIPS_TXT, FIPS_CT, 1'b0, 14, 1'b0};
    vecs[6] = '{1, 0, {4{32'h11111111}}, {4{32'h22222222}}, 128'd0, 1'b1, 14, 1'b1};
    vecs[7] = '{1, 2, 128'd0, {4{32'ha5a5a5a5}}, {4{32'ha5a5a5a5}}, 1'b0, 14, 1'b0};

    req_valid[0] = '0; req_valid[1] = '0;
    rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1;
    req_key = '0; req_text = '0;
    suppress[0] = 1'b0; suppress[1] = 1'b0;
    force_done[0] = 1'b0; force_done[1] = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 128'(req_ready[0]), 128'd0);
    check("rst_rsp_valid", 128'(rsp_valid[0]), 128'd0);
    check("rst_rsp_err", 128'(rsp_err[0]), 128'd0);
    check("rst_rsp_id", 128'(rsp_id[0]), 128'd0);
    check("rst_rsp_data", rsp_data[0], 128'd0);
    check("rst_busy", 128'(busy[0]), 128'd0);
    check("rst_core_ld", 128'(core_ld[0]), 128'd0);
    check("rst_core_key", core_key[0], 128'd0);
    check("rst_core_text_in", core_text_in[0], 128'd0);
    check("rst_busy12", 128'(busy[1]), 128'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Table of single jobs: FIPS vector, XOR vectors, watchdog, deadline boundary
    foreach (vecs[v]) begin
      suppress[vecs[v].sel] = vecs[v].sup;
      run_job(vecs[v].sel, vecs[v].id, vecs[v].key, vecs[v].text,
              vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_lat);
      suppress[vecs[v].sel] = 1'b0;
      $display("[TB] vector %0d inst %0d id %0d done", v, vecs[v].sel, vecs[v].id);
    end

    // Spurious core_done while idle must not produce a response
    @(posedge clk); #1 force_done[0] = 1'b1;
    @(posedge clk); #1 force_done[0] = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[0] || busy[0]) bad++;
    end
    check("spurious_done_ignored", 128'(bad), 128'd0);
    $display("[TB] spurious done sequence done");

    // Round-robin fairness with all requesters held valid
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_key[i*128 +: 128]  = 128'(i + 1);
      req_text[i*128 +: 128] = 128'(i * 16);
    end
    req_valid[0] = '1;
    gcount = 0;
    for (int i = 0; i < 100 && gcount < 5; i++) begin
      @(negedge clk);
      if (req_ready[0] != '0) begin
        check("rr_onehot", 128'($onehot(req_ready[0])), 128'd1);
        for (int b = 0; b < NREQ; b++) if (req_ready[0][b]) gid[gcount] = b;
        gcyc[gcount] = cyc;
        gcount++;
      end
    end
    check("rr_count", 128'(gcount), 128'd5);
    for (int k = 0; k < 5; k++) begin
      check("rr_order", 128'(gid[k]), 128'(rr_exp[k]));
      if (k > 0) check("rr_spacing", 128'(gcyc[k] - gcyc[k-1]), 128'd14);
    end
    @(posedge clk); #1 req_valid[0] = '0;
    $display("[TB] round-robin sequence done, %0d grants", gcount);

    // Backpressure: response held for 40 cycles while requester 1 waits
    apply_reset();
    rsp_ready[0] = 1'b0;
    req_key[0 +: 128]    = {4{32'h11111111}};
    req_text[0 +: 128]   = {4{32'h22222222}};
    req_key[128 +: 128]  = {4{32'hffffffff}};
    req_text[128 +: 128] = {2{64'h0123456789abcdef}};
    req_valid[0] = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[0] != '0) break;
    end
    g = cyc;
    check("bp_grant0", 128'(req_ready[0]), 128'd1);
    @(posedge clk); #1 req_valid[0] = 4'b0010;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) break;
    end
    check("bp_latency", 128'(cyc - g), 128'd14);
    held = rsp_data[0];
    check("bp_data", held, {4{32'h33333333}});
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (!rsp_valid[0] || rsp_data[0] !== held || rsp_id[0] !== 2'd0 || req_ready[0] != '0) bad++;
    end
    check("bp_hold_stable", 128'(bad), 128'd0);
    @(posedge clk); #1 rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_grant1_on_ready", 128'(req_ready[0]), 128'd2);
    g = cyc;
    @(posedge clk); #1 req_valid[0] = '0;
    @(negedge clk);
    check("bp_rsp_drained", 128'(rsp_valid[0]), 128'd0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) break;
    end
    check("bp2_latency", 128'(cyc - g), 128'd14);
    check("bp2_id", 128'(rsp_id[0]), 128'd1);
    check("bp2_data", rsp_data[0], {2{64'hfedcba9876543210}});
    $display("[TB] backpressure sequence done");

    // Reset in the middle of RUN; the core's late done must be ignored
    apply_reset();
    req_key[256 +: 128]  = 128'd0;
    req_text[256 +: 128] = {4{32'ha5a5a5a5}};
    req_valid[0] = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[0] != '0) break;
    end
    check("mid_grant", 128'(req_ready[0]), 128'd4);
    @(posedge clk); #1 req_valid[0] = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("mid_busy_before", 128'(busy[0]), 128'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_busy_reset", 128'(busy[0]), 128'd0);
    check("mid_rsp_valid_reset", 128'(rsp_valid[0]), 128'd0);
    check("mid_core_ld_reset", 128'(core_ld[0]), 128'd0);
    @(posedge clk); #1 rst = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid[0] || busy[0]) bad++;
    end
    check("mid_late_done_ignored", 128'(bad), 128'd0);
    run_job(0, 1, FIPS_KEY, FIPS_TXT, FIPS_CT, 1'b0, 14);
    $display("[TB] reset mid-job sequence done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
